victim_buffer: RTL

- Parametrised, fully associative victim buffer between L2 cache (mem_* side) and physical memory (pmem_* side).
- Captures lines evicted by L2, serves L2 read misses that hit a buffered victim, and forwards other misses to pmem.
- Writes back the victim's own victims to pmem when it is full.
- Successor to the fixed single-line victim: configurable entry count, line and address width, exclusive swap-on-hit, and round-robin replacement.

---
 rtl/victim_buffer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/victim_buffer.sv
// ---------------------------------------------------------------------------
// victim_buffer : fully associative victim buffer between L2 and pmem.
// Optional write-back drain of idle entries: VICTIM_DRAIN_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module victim_buffer #(
  parameter int ENTRIES     = 4,
  parameter int ADDR_W      = 16,
  parameter int LINE_W      = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_write,
  input  logic              mem_read,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE, WR_UPD, WR_ALLOC, EVICT, RD_HIT, RD_MISS
`ifdef VICTIM_DRAIN_EN
    , DRAIN
`endif
  } state_t;

  state_t state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_d  [ENTRIES];
  logic [LINE_W-1:0]  data_q [ENTRIES];
  logic [LINE_W-1:0]  data_d [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               mem_resp_q, mem_resp_d;
  logic [LINE_W-1:0]  mem_rdata_q, mem_rdata_d;
  logic               pmem_read_q, pmem_read_d;
  logic               pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0]  pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0]  pmem_wdata_q, pmem_wdata_d;

  logic [TAG_W-1:0] req_tag;
  logic             unused_offset;
  logic             hit, has_free;
  logic [IDX_W-1:0] hit_idx, free_idx;
`ifdef VICTIM_DRAIN_EN
  logic             any_valid;
  logic [IDX_W-1:0] first_valid;
`endif

  assign req_tag       = mem_address[ADDR_W-1:OFFSET_BITS];
  assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
`ifdef VICTIM_DRAIN_EN
    any_valid   = 1'b0;
    first_valid = '0;
`endif
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
`ifdef VICTIM_DRAIN_EN
      if (valid_q[i]) begin
        any_valid   = 1'b1;
        first_valid = IDX_W'(i);
      end
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    data_d         = data_q;
    rr_ptr_d       = rr_ptr_q;
    mem_resp_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      IDLE: begin
        // The request still visible during the mem_resp cycle is the old one.
        if (!mem_resp_q) begin
          if (mem_write) begin
            if (hit) begin
              state_d = WR_UPD;
            end else if (has_free) begin
              state_d = WR_ALLOC;
            end else begin
              state_d        = EVICT;
              pmem_write_d   = 1'b1;
              pmem_address_d = {tag_q[rr_ptr_q], {OFFSET_BITS{1'b0}}};
              pmem_wdata_d   = data_q[rr_ptr_q];
            end
          end else if (mem_read) begin
            if (hit) begin
              state_d = RD_HIT;
            end else begin
              state_d        = RD_MISS;
              pmem_read_d    = 1'b1;
              pmem_address_d = {req_tag, {OFFSET_BITS{1'b0}}};
            end
          end
`ifdef VICTIM_DRAIN_EN
          else if (any_valid) begin
            state_d        = DRAIN;
            pmem_write_d   = 1'b1;
            pmem_address_d = {tag_q[first_valid], {OFFSET_BITS{1'b0}}};
            pmem_wdata_d   = data_q[first_valid];
          end
`endif
        end
      end
      WR_UPD: begin
        data_d[hit_idx] = mem_wdata;
        mem_resp_d      = 1'b1;
        state_d         = IDLE;
      end
      WR_ALLOC: begin
        data_d[free_idx]  = mem_wdata;
        tag_d[free_idx]   = req_tag;
        valid_d[free_idx] = 1'b1;
        mem_resp_d        = 1'b1;
        state_d           = IDLE;
      end
      EVICT: begin
        if (pmem_resp) begin
          pmem_write_d      = 1'b0;
          valid_d[rr_ptr_q] = 1'b0;
          rr_ptr_d          = rr_ptr_q + IDX_W'(1);
          state_d           = WR_ALLOC;
        end
      end
      RD_HIT: begin
        // Exclusive: the line moves to L2 and leaves the buffer.
        mem_rdata_d      = data_q[hit_idx];
        valid_d[hit_idx] = 1'b0;
        mem_resp_d       = 1'b1;
        state_d          = IDLE;
      end
      RD_MISS: begin
        if (pmem_resp) begin
          pmem_read_d = 1'b0;
          mem_rdata_d = pmem_rdata;
          mem_resp_d  = 1'b1;
          state_d     = IDLE;
        end
      end
`ifdef VICTIM_DRAIN_EN
      DRAIN: begin
        if (pmem_resp) begin
          pmem_write_d         = 1'b0;
          valid_d[first_valid] = 1'b0;
          state_d              = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      rr_ptr_q       <= '0;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      rr_ptr_q       <= rr_ptr_d;
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  // Tag/data payload is qualified by valid_q and needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign mem_resp     = mem_resp_q;
  assign mem_rdata    = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule

`default_nettype wire
